// File: rtl/gene_sweep_ctrl.sv
// Sweep controller for the 8-bit Boolean gene network: finds the attractor of
// every initial state in a range with Brent's cycle detection and streams results.
module gene_sweep_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [W-1:0]   first_val,
  input  logic [W-1:0]   last_val,
  output logic [W-1:0]   net_x,
  input  logic [W-1:0]   net_nx,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W-1:0]   res_init,
  output logic [W-1:0]   res_attr,
  output logic [W:0]     res_period,
  output logic           res_fixed,
  output logic [W:0]     fixed_cnt,
  output logic [W:0]     cycle_cnt,
  output logic           busy,
  output logic           done
);

  localparam int unsigned PW = W + 1;
  localparam int unsigned QW = W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEEK,
    S_CANON,
    S_REPORT
  } state_e;

  state_e         state_q;
  logic [W-1:0]   init_q;
  logic [W-1:0]   last_q;
  logic [W-1:0]   tort_q;
  logic [W-1:0]   min_q;
  logic [QW-1:0]  pow_q;
  logic [PW-1:0]  lam_q;
  logic [PW-1:0]  period_q;
  logic [PW-1:0]  cnt_q;

  logic [PW-1:0]  lam_n;
  logic [PW-1:0]  cnt_n;
  logic [W-1:0]   min_n;

  // Step counters and the running attractor minimum for this cycle.
  always_comb begin
    lam_n = lam_q + PW'(1);
    cnt_n = cnt_q + PW'(1);
    min_n = (net_nx < min_q) ? net_nx : min_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      init_q     <= '0;
      last_q     <= '0;
      tort_q     <= '0;
      min_q      <= '0;
      pow_q      <= '0;
      lam_q      <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      net_x      <= '0;
      res_valid  <= 1'b0;
      res_init   <= '0;
      res_attr   <= '0;
      res_period <= '0;
      res_fixed  <= 1'b0;
      fixed_cnt  <= '0;
      cycle_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state_q   <= S_IDLE;
        res_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              init_q    <= first_val;
              last_q    <= last_val;
              fixed_cnt <= '0;
              cycle_cnt <= '0;
              busy      <= 1'b1;
              state_q   <= S_LOAD;
            end
          end
          S_LOAD: begin
            tort_q  <= init_q;
            net_x   <= init_q;
            pow_q   <= QW'(1);
            lam_q   <= '0;
            state_q <= S_SEEK;
          end
          // Brent: tortoise teleports to the hare at every power-of-two step count.
          S_SEEK: begin
            net_x <= net_nx;
            if (net_nx == tort_q) begin
              period_q <= lam_n;
              min_q    <= tort_q;
              cnt_q    <= '0;
              if (lam_n == PW'(1)) begin
                res_init   <= init_q;
                res_attr   <= tort_q;
                res_period <= lam_n;
                res_fixed  <= 1'b1;
                res_valid  <= 1'b1;
                state_q    <= S_REPORT;
              end else begin
                state_q <= S_CANON;
              end
            end else if ({1'b0, lam_n} == pow_q) begin
              tort_q <= net_nx;
              pow_q  <= pow_q << 1;
              lam_q  <= '0;
            end else begin
              lam_q <= lam_n;
            end
          end
          S_CANON: begin
            net_x <= net_nx;
            min_q <= min_n;
            cnt_q <= cnt_n;
            if (cnt_n == period_q - PW'(1)) begin
              res_init   <= init_q;
              res_attr   <= min_n;
              res_period <= period_q;
              res_fixed  <= 1'b0;
              res_valid  <= 1'b1;
              state_q    <= S_REPORT;
            end
          end
          S_REPORT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (res_fixed) fixed_cnt <= fixed_cnt + PW'(1);
              else           cycle_cnt <= cycle_cnt + PW'(1);
              if (init_q == last_q) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                init_q  <= init_q + W'(1);
                state_q <= S_LOAD;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/gene_sweep_ctrl.md
# gene_sweep_ctrl

Sweep controller for the 8-bit Boolean gene network datapath. It steps the external next-state logic from each initial state in a programmed range, one state per clock. For every initial state it finds the attractor using Brent's cycle detection, reports whether that attractor is a fixed point or a cycle, and gives its period and canonical state. Results go out one per initial state over a valid/ready port, and the block keeps running fixed-point and cycle counts.

## Interface
- W, 8: network state width; the sweep covers 2^W states.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a sweep; ignored unless in IDLE.
- abort  in  1  synchronous; from any state, return to IDLE next edge.
- first_val  in  W  first initial state, sampled on start.
- last_val  in  W  last initial state, sampled on start.
- net_x  out  W  current state driven into the network datapath (hare register).
- net_nx  in  W  next state from the datapath, combinational function of net_x.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_init  out  W  initial state of this result.
- res_attr  out  W  minimum state value on the attractor.
- res_period  out  W+1  attractor length, 1..2^W.
- res_fixed  out  1  1 when res_period==1.
- fixed_cnt  out  W+1  fixed-point results accepted since start.
- cycle_cnt  out  W+1  cycle results accepted since start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last result is accepted.

## Operation
- States: IDLE, LOAD, SEEK, CANON, REPORT.
- IDLE, with start: init <= first_val, last <= last_val, both counts <= 0, go to LOAD.
- LOAD (1 cycle): tort <= init, hare <= init, pow <= 1, lam <= 0, then go to SEEK.
- SEEK: let lam_n = lam+1 and hare <= net_nx. Check the match rule first, then the power-of-two rule.
  - Match: if net_nx==tort, period <= lam_n, min <= tort, go to CANON. If lam_n==1, go straight to REPORT instead.
  - Power of two: else if lam_n==pow, tort <= net_nx, pow <= pow<<1, lam <= 0.
  - Otherwise: lam <= lam_n.
- Register widths: pow needs W+2 bits and lam needs W+1 bits. Counters wrap modulo their width.
- CANON walks the cycle for period-1 cycles. Each cycle: hare <= net_nx, min <= min(min, net_nx), cnt++. Exit to REPORT once period-1 steps are done.
- REPORT: res_valid=1, and all res_* outputs stay stable until res_ready.
  - On the accepting edge, increment fixed_cnt if period==1, else increment cycle_cnt.
  - Then, if init==last: go to IDLE and pulse done. Otherwise init <= init+1 (mod 2^W) and go to LOAD.
- Range wraps: first_val > last_val sweeps across 2^W-1 to 0. first_val==last_val gives exactly one result.
- abort clears res_valid and goes to IDLE. done is not pulsed, and the counts hold their values.

## Timing
- Reset values: net_x=0, res_valid=0, res_init=0, res_attr=0, res_period=0, res_fixed=0, both counts 0, busy=0, done=0, state IDLE.
- Reset is asynchronous: asserting rst_n mid-sweep immediately forces the reset values, and no partial result survives.
- busy rises on the edge after start is sampled.
- Per initial state, with res_ready held high: 1 (LOAD) + S (SEEK) + (period-1) (CANON) + 1 (REPORT) cycles.
- Fixed point from init: S=1, so 3 cycles per result.
- net_nx is sampled in the same cycle as net_x and must settle within one clock.
- res_* change only on entry to REPORT.
- done is high for exactly the cycle after the final accept; busy is 0 in that same cycle.

## Test plan
- Identity stub (net_nx=net_x), sweep 0..255 with ready high:
  - 256 results, each with res_attr=res_init, period 1, res_fixed=1.
  - fixed_cnt=256, cycle_cnt=0.
  - Each result takes 3 cycles; done pulses once.
- Increment stub (net_nx=net_x+1), sweep 5..5:
  - One result: attr 0, period 256, fixed 0.
  - cycle_cnt=1.
- XOR stub (net_nx=net_x^1), sweep 0xFE..0x01 (wrap):
  - Results in order for init FE, FF, 00, 01.
  - Each has period 2 and attr=init&FE.
  - cycle_cnt=4.
- Real gene network datapath, with results checked against a reference model:
  - init 0: fixed, attr 0x00.
  - init 99: fixed, attr 0x53.
  - init 255: fixed, attr 0x53.
  - init 56: cycle, and the attractor contains 0x1C.
  - init 124: cycle, and the attractor contains 0xB2.
- Backpressure: hold res_ready low for 10 cycles in REPORT.
  - res_valid and res_* stay stable, and no count changes.
  - The accept is taken on the edge where ready rises.
- Abort mid-SEEK and rst_n low mid-CANON:
  - Abort: IDLE next edge, res_valid=0, no done.
  - Reset: all outputs go to their reset values without waiting for a clock.
  - A subsequent start runs the sweep correctly.
